// File: rtl/fence_t_sequencer_if.sv
// fence_t_sequencer_if
//  Groups every non-clock/reset signal of the fence.t microreset sequencer.
//  Handshakes on this bundle:
//    fence_t_i    1-cycle request pulse. It is accepted only in IDLE. Outside IDLE
//                 it is refused, and drop_o pulses one cycle later.
//    flush_o      per-cache level request; held until that cache returns a
//                 1-cycle flush_ack_i pulse, dropped the following cycle.
//    ceil_valid_o 1-cycle qualifier for ceil_o. There is no back-pressure.
//  Modports:
//    slave  - the sequencer (consumes requests, drives status/outputs)
//    master - the core-side environment driving the sequencer
interface fence_t_sequencer_if #(
  parameter int NrCaches = 2,
  parameter int NrPadSrc = 2,
  parameter int PadWidth = 32,
  parameter int VLEN     = 64,
  parameter int SelW     = (NrPadSrc > 1) ? $clog2(NrPadSrc) : 1
);
  logic                fence_t_i;
  logic [VLEN-1:0]     pc_commit_i;
  logic [VLEN-1:0]     boot_addr_i;
  logic [VLEN-1:0]     rst_addr_o;
  logic [NrCaches-1:0] flush_o;
  logic [NrCaches-1:0] flush_ack_i;
  logic [NrCaches-1:0] cache_busy_i;
  logic [NrPadSrc-1:0] pad_evt_i;
  logic [SelW-1:0]     pad_sel_i;
  logic [PadWidth-1:0] pad_cycles_i;
  logic [PadWidth-1:0] ceil_o;
  logic                ceil_valid_o;
  logic                halt_o;
  logic                stall_cache_o;
  logic                rst_uarch_no;
  logic                cache_init_no;
  logic                drop_o;

  modport slave (
    input  fence_t_i, pc_commit_i, boot_addr_i, flush_ack_i, cache_busy_i,
           pad_evt_i, pad_sel_i, pad_cycles_i,
    output rst_addr_o, flush_o, ceil_o, ceil_valid_o, halt_o, stall_cache_o,
           rst_uarch_no, cache_init_no, drop_o
  );

  modport master (
    output fence_t_i, pc_commit_i, boot_addr_i, flush_ack_i, cache_busy_i,
           pad_evt_i, pad_sel_i, pad_cycles_i,
    input  rst_addr_o, flush_o, ceil_o, ceil_valid_o, halt_o, stall_cache_o,
           rst_uarch_no, cache_init_no, drop_o
  );
endinterface

// File: rtl/fence_t_sequencer.sv
// fence_t_sequencer
//  fence.t microreset sequencer. A committed fence.t walks through
//  IDLE -> FLUSH -> DRAIN -> PAD -> RST_UARCH -> IDLE:
//    FLUSH     request a flush from every cache and wait until each one has acked
//    DRAIN     wait for DrainCycles consecutive cycles with no cache busy
//    PAD       wait for the pad counter, armed by the selected event, to expire
//    RST_UARCH hold rst_uarch_no low for RstCycles cycles
//  Commit is halted, and the caches are stalled, whenever the FSM is not IDLE.
// Ports
//  clk_i   clock
//  rst_ni  asynchronous reset, active low
//  clr_i   synchronous clear; it has the same effect as reset
//  bus     fence_t_sequencer_if.slave (fence request, cache flush/busy, pad, outputs)
//  state_o current FSM state, for debug
module fence_t_sequencer #(
  parameter int NrCaches    = 2,
  parameter int NrPadSrc    = 2,
  parameter int PadWidth    = 32,
  parameter int DrainCycles = 16,
  parameter int RstCycles   = 16,
  parameter int InitHold    = 3,
  parameter int VLEN        = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  fence_t_sequencer_if.slave      bus,
  output logic [2:0]              state_o
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_PAD   = 3'd3;
  localparam logic [2:0] ST_RST   = 3'd4;

  localparam int DrainW = $clog2(DrainCycles + 1);
  localparam int RstW   = (RstCycles > 1) ? $clog2(RstCycles) : 1;
  localparam int HoldW  = (InitHold > 0) ? $clog2(InitHold + 1) : 1;

  logic [2:0]          state_q, state_d;
  logic [NrCaches-1:0] ack_mask_q, ack_mask_d;
  logic [NrCaches-1:0] flush_q, flush_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [PadWidth-1:0] pad_cnt_q, pad_cnt_d;
  logic [NrPadSrc-1:0] evt_q, evt_d;
  logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [PadWidth-1:0] ceil_q, ceil_d;
  logic                ceil_valid_q, ceil_valid_d;
  logic                init_q, init_d;
  logic                drop_q, drop_d;
  logic [VLEN-1:0]     rst_addr_q, rst_addr_d;

  logic                pad_edge;
  logic [NrCaches-1:0] ack_all;

  always_comb begin
    state_d      = state_q;
    ack_mask_d   = ack_mask_q;
    flush_d      = '0;
    drain_cnt_d  = drain_cnt_q;
    pad_cnt_d    = pad_cnt_q;
    evt_d        = bus.pad_evt_i;
    rst_cnt_d    = rst_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    ceil_d       = ceil_q;
    ceil_valid_d = 1'b0;
    init_d       = 1'b0;
    drop_d       = 1'b0;
    rst_addr_d   = rst_addr_q;
    pad_edge     = 1'b0;
    ack_all      = ack_mask_q | bus.flush_ack_i;

    // The idle-cycle counter runs in every state, so DRAIN can finish on its
    // first cycle if the caches were already quiet for long enough.
    if (|bus.cache_busy_i) begin
      drain_cnt_d = '0;
    end else if (drain_cnt_q != DrainW'(DrainCycles)) begin
      drain_cnt_d = drain_cnt_q + DrainW'(1);
    end

    // Each source keeps its own edge register. Because of that, switching
    // pad_sel_i to a source that is already high does not look like an edge.
    if (int'(bus.pad_sel_i) < NrPadSrc) begin
      pad_edge = bus.pad_evt_i[bus.pad_sel_i] & ~evt_q[bus.pad_sel_i];
    end
    if (pad_edge) begin
      pad_cnt_d = bus.pad_cycles_i;
    end else if (pad_cnt_q != '0) begin
      pad_cnt_d = pad_cnt_q - PadWidth'(1);
    end

    // cache_init_no follows RST_UARCH one cycle late. It then stays high for
    // InitHold more cycles.
    if (state_q == ST_RST) begin
      hold_cnt_d = HoldW'(InitHold);
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HoldW'(1);
    end
    init_d = (state_q == ST_RST) || (hold_cnt_q != '0);

    if (bus.fence_t_i && (state_q != ST_IDLE)) begin
      drop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.fence_t_i) begin
          state_d    = ST_FLUSH;
          rst_addr_d = bus.pc_commit_i + VLEN'(4);
        end
      end
      ST_FLUSH: begin
        if (&ack_all) begin
          state_d    = ST_DRAIN;
          ack_mask_d = '0;
        end else begin
          ack_mask_d = ack_all;
          flush_d    = ~ack_all;
        end
      end
      ST_DRAIN: begin
        // The check uses the next count, so it includes the current cycle. The
        // FSM leaves on the cycle that completes DrainCycles idle cycles.
        if (drain_cnt_d == DrainW'(DrainCycles)) begin
          state_d      = ST_PAD;
          ceil_valid_d = 1'b1;
          ceil_d       = (pad_cnt_q == '0) ? '0 : bus.pad_cycles_i - pad_cnt_q;
        end
      end
      ST_PAD: begin
        if (pad_cnt_q == '0) begin
          state_d = ST_RST;
        end
      end
      ST_RST: begin
        if (rst_cnt_q == RstW'(RstCycles - 1)) begin
          state_d   = ST_IDLE;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ack_mask_d = '0;
        rst_cnt_d  = '0;
      end
    endcase

    if (clr_i) begin
      state_d      = ST_IDLE;
      ack_mask_d   = '0;
      flush_d      = '0;
      drain_cnt_d  = '0;
      pad_cnt_d    = '0;
      evt_d        = '0;
      rst_cnt_d    = '0;
      hold_cnt_d   = '0;
      ceil_d       = '0;
      ceil_valid_d = 1'b0;
      init_d       = 1'b0;
      drop_d       = 1'b0;
      rst_addr_d   = bus.boot_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      ack_mask_q   <= '0;
      flush_q      <= '0;
      drain_cnt_q  <= '0;
      pad_cnt_q    <= '0;
      evt_q        <= '0;
      rst_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      ceil_q       <= '0;
      ceil_valid_q <= 1'b0;
      init_q       <= 1'b0;
      drop_q       <= 1'b0;
      rst_addr_q   <= bus.boot_addr_i;
    end else begin
      state_q      <= state_d;
      ack_mask_q   <= ack_mask_d;
      flush_q      <= flush_d;
      drain_cnt_q  <= drain_cnt_d;
      pad_cnt_q    <= pad_cnt_d;
      evt_q        <= evt_d;
      rst_cnt_q    <= rst_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      ceil_q       <= ceil_d;
      ceil_valid_q <= ceil_valid_d;
      init_q       <= init_d;
      drop_q       <= drop_d;
      rst_addr_q   <= rst_addr_d;
    end
  end

  assign bus.rst_addr_o    = rst_addr_q;
  assign bus.flush_o       = flush_q;
  assign bus.ceil_o        = ceil_q;
  assign bus.ceil_valid_o  = ceil_valid_q;
  assign bus.halt_o        = (state_q != ST_IDLE);
  assign bus.stall_cache_o = (state_q != ST_IDLE);
  assign bus.rst_uarch_no  = (state_q != ST_RST);
  assign bus.cache_init_no = init_q;
  assign bus.drop_o        = drop_q;
  assign state_o           = state_q;
endmodule
